// File: rtl/dll_pkg.sv
// Shared constants and types for the tap-select delay-locked loop.
package dll_pkg;

  localparam int TAPS  = 64;
  localparam int SEL_W = 6;

  localparam logic [SEL_W-1:0] SEL_RST = 6'd16;
  localparam logic [SEL_W-1:0] SEL_MIN = 6'd1;
  localparam logic [SEL_W-1:0] SEL_MAX = 6'd63;

  // Reversal count at which the loop is considered locked (also the
  // saturation value of the 2-bit reversal counter).
  localparam logic [1:0] LOCK_REVS = 2'd3;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // One saturating step of the tap select in the given direction.
  function automatic logic [SEL_W-1:0] sel_step(input logic [SEL_W-1:0] sel,
                                                input dir_e dir);
    logic [SEL_W-1:0] nxt;
    nxt = sel;
    if (dir == DIR_UP) begin
      if (sel != SEL_MAX) nxt = sel + 6'd1;
    end else begin
      if (sel != SEL_MIN) nxt = sel - 6'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/dll_delay_line.sv
// Shift-register delay line of the synchronized reference plus tap mux.
// Tap 0 is rs itself; tap k is rs as it was k clocks ago.
module dll_delay_line
  import dll_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rs,
  input  logic [SEL_W-1:0] sel,
  output logic             tap
);

  // Only taps 1..63 need storage; tap 0 is the live rs input.
  logic [TAPS-1:1] d_q;
  logic [TAPS-1:1] d_d;
  logic [TAPS-1:0] taps;

  // Shift every tap one position older and load rs into tap 1.
  always_comb begin
    d_d = {d_q[TAPS-2:1], rs};
  end

  assign taps = {d_q, rs};
  assign tap  = taps[sel];

  // Delay-line register, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= '0;
    end else begin
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/tt_um_dpetrisko_ttdll.sv
// Digital DLL: synchronizes ref, detects its rising edge, and steers a
// delay-line tap so the delayed copy straddles that edge. Lock is declared
// after the tap direction has reversed three updates in a row.
module tt_um_dpetrisko_ttdll
  import dll_pkg::*;
(
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic rst;
  logic manual;
  logic rs;
  logic rise;
  logic tap;
  dir_e dir;

  logic [1:0]       sync_q,     sync_d;
  logic             rs_dly_q,   rs_dly_d;
  logic [SEL_W-1:0] sel_q,      sel_d;
  dir_e             prev_dir_q, prev_dir_d;
  logic [1:0]       rev_cnt_q,  rev_cnt_d;
  logic             locked_q,   locked_d;
  logic [SEL_W-1:0] man_sel;

  // Pins that carry no function in this design.
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, ui_in[7:2], uio_in[7:6]};

  assign rst    = ~rst_n;
  assign manual = ui_in[1];
  assign rs     = sync_q[1];

  // A manual select of 0 would pick the undelayed input; clamp it to 1.
  assign man_sel = (uio_in[SEL_W-1:0] == '0) ? SEL_MIN : uio_in[SEL_W-1:0];

  dll_delay_line u_delay_line (
    .clk (clk),
    .rst (rst),
    .rs  (rs),
    .sel (sel_q),
    .tap (tap)
  );

  // Synchronizer advance and rising-edge detect on the synchronized ref.
  always_comb begin
    sync_d   = {sync_q[0], ui_in[0]};
    rs_dly_d = rs;
    rise     = rs & ~rs_dly_q;
  end

  // Phase detector, tap select counter and lock tracking.
  always_comb begin
    dir        = tap ? DIR_UP : DIR_DOWN;
    sel_d      = sel_q;
    prev_dir_d = prev_dir_q;
    rev_cnt_d  = rev_cnt_q;
    if (manual) begin
      // Manual mode owns the select and parks the lock tracker so the
      // loop restarts cleanly (as if last moving up) when released.
      sel_d      = man_sel;
      prev_dir_d = DIR_UP;
      rev_cnt_d  = 2'd0;
    end else if (rise) begin
      // Tap already high at the edge means the delay is too short: go up.
      // A saturated step still counts as a direction for lock purposes.
      sel_d = sel_step(sel_q, dir);
      if (dir != prev_dir_q) begin
        rev_cnt_d = (rev_cnt_q == LOCK_REVS) ? LOCK_REVS : rev_cnt_q + 2'd1;
      end else begin
        rev_cnt_d = 2'd0;
      end
      prev_dir_d = dir;
    end
    locked_d = (rev_cnt_d == LOCK_REVS);
  end

  // State registers; reset overrides both manual and auto updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= 2'b00;
      rs_dly_q   <= 1'b0;
      sel_q      <= SEL_RST;
      prev_dir_q <= DIR_UP;
      rev_cnt_q  <= 2'd0;
      locked_q   <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      rs_dly_q   <= rs_dly_d;
      sel_q      <= sel_d;
      prev_dir_q <= prev_dir_d;
      rev_cnt_q  <= rev_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign uo_out  = {sel_q, locked_q, tap};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_dpetrisko_ttdll.sv
// Directed bench for the tap-select DLL: reset values, lock at ref period
// 20, mid-lock reset, hold with no edges, upper saturation, manual tap and
// manual clamp. Inputs change on the falling edge; outputs are sampled on
// the falling edge just before the next change.
module tb_tt_um_dpetrisko_ttdll;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       ref_bit = 1'b0;
  logic       manual_bit = 1'b0;
  logic [5:0] tap_sel = 6'd0;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int vec_cnt = 0;
  int err_cnt = 0;

  assign ui_in  = {6'b000000, manual_bit, ref_bit};
  assign uio_in = {2'b00, tap_sel};

  tt_um_dpetrisko_ttdll dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  // Clock
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One ref period: high for hi clocks, then low for lo clocks.
  task automatic ref_period(input int hi, input int lo);
    ref_bit = 1'b1;
    repeat (hi) @(negedge clk);
    ref_bit = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // Lock run at ref period 20. The delay line is first filled with real
  // ref history while manual mode parks sel at 16; otherwise the first
  // rise after reset would see cleared taps and step down instead of up.
  task automatic run_lock_seq(input string tag);
    int exp_sel  [12] = '{17, 18, 19, 20, 21, 20, 21, 20, 21, 20, 21, 20};
    int exp_lock [12] = '{ 0,  0,  0,  0,  0,  0,  0,  1,  1,  1,  1,  1};
    manual_bit = 1'b1;
    tap_sel    = 6'd16;
    repeat (3) ref_period(10, 10);
    check({tag, "_prime_sel"}, 32'(uo_out[7:2]), 32'd16);
    check({tag, "_prime_lock"}, 32'(uo_out[1]), 32'd0);
    manual_bit = 1'b0;
    for (int k = 0; k < 12; k++) begin
      ref_period(10, 10);
      check($sformatf("%s_rise%0d_sel", tag, k + 1), 32'(uo_out[7:2]), 32'(exp_sel[k]));
      check($sformatf("%s_rise%0d_lock", tag, k + 1), 32'(uo_out[1]), 32'(exp_lock[k]));
    end
  endtask

  initial begin
    logic [39:0] pat;
    int sat_sel [4] = '{61, 62, 63, 63};
    pat = 40'hB4_E19A_3725;

    // Reset: 5 clocks low, then release.
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_uo_out", 32'(uo_out), 32'h40);
    check("rst_uio_out", 32'(uio_out), 32'h00);
    check("rst_uio_oe", 32'(uio_oe), 32'h00);

    // Lock at period 20.
    run_lock_seq("lock");

    // No ref edges: sel and locked hold.
    repeat (60) @(negedge clk);
    check("hold_sel", 32'(uo_out[7:2]), 32'd20);
    check("hold_lock", 32'(uo_out[1]), 32'd1);

    // Mid-lock reset for one clock, then the lock run again.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_uo_out", 32'(uo_out), 32'h40);
    @(negedge clk);
    check("midrst_sel", 32'(uo_out[7:2]), 32'd16);
    check("midrst_lock", 32'(uo_out[1]), 32'd0);
    run_lock_seq("relock");

    // Upper saturation: ref period 200 (high 150, low 50). At each rise the
    // last 50 samples are low and the 150 before are high, so taps 51..63
    // read 1 and the select only moves up.
    manual_bit = 1'b1;
    tap_sel    = 6'd60;
    @(negedge clk);
    check("sat_manual_sel", 32'(uo_out[7:2]), 32'd60);
    check("sat_manual_lock", 32'(uo_out[1]), 32'd0);
    // Reset wins over a manual request in the same clock.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_over_manual_sel", 32'(uo_out[7:2]), 32'd16);
    ref_period(150, 50);
    check("sat_prime_sel", 32'(uo_out[7:2]), 32'd60);
    manual_bit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ref_period(150, 50);
      check($sformatf("sat_rise%0d_sel", k + 1), 32'(uo_out[7:2]), 32'(sat_sel[k]));
      check($sformatf("sat_rise%0d_lock", k + 1), 32'(uo_out[1]), 32'd0);
    end

    // Manual tap 5: dout is ref as captured 6 rising edges earlier
    // (2 synchronizer stages behind rs, then 5 taps less the shared edge),
    // i.e. the bit driven 7 falling-edge steps ago.
    manual_bit = 1'b1;
    tap_sel    = 6'd5;
    ref_bit    = 1'b0;
    @(negedge clk);
    check("man5_sel", 32'(uo_out[7:2]), 32'd5);
    check("man5_lock", 32'(uo_out[1]), 32'd0);
    for (int i = 0; i < 40; i++) begin
      if (i >= 7) begin
        check($sformatf("man5_dout%0d", i), 32'(uo_out[0]), 32'(pat[i-7]));
      end
      ref_bit = pat[i];
      @(negedge clk);
    end

    // Manual clamp: select 0 becomes 1.
    tap_sel = 6'd0;
    @(negedge clk);
    check("clamp_sel", 32'(uo_out[7:2]), 32'd1);
    check("clamp_uio_out", 32'(uio_out), 32'h00);
    check("clamp_uio_oe", 32'(uio_oe), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
